// File: rtl/mux_rr_pkg.sv
// Shared definitions for the round-robin word mux: FSM encoding, default
// parameters and a constant clog2 helper.
package mux_rr_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  localparam int DEF_N     = 4;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_BURST = 2;

  // Width of the burst counter; BURST tops out at 15.
  localparam int BCW = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_rr_arb_if.sv
// Channel-side and lane-side signals of mux_rr_arb. The chan_out tag is
// present only when MUX_RR_CHAN_ID_EN is defined.
interface mux_rr_arb_if #(
  parameter int N     = mux_rr_pkg::DEF_N,
  parameter int WIDTH = mux_rr_pkg::DEF_WIDTH
);
  localparam int CW = mux_rr_pkg::clog2(N);

  logic [N*WIDTH-1:0] data_in;
  logic [N-1:0]       valid_in;
  logic [N-1:0]       pop;
  logic [WIDTH-1:0]   data_out;
  logic               valid_out;
  logic               ready_out;
`ifdef MUX_RR_CHAN_ID_EN
  logic [CW-1:0]      chan_out;

  modport slave  (input  data_in, valid_in, ready_out,
                  output pop, data_out, valid_out, chan_out);
  modport master (output data_in, valid_in, ready_out,
                  input  pop, data_out, valid_out, chan_out);
`else
  modport slave  (input  data_in, valid_in, ready_out,
                  output pop, data_out, valid_out);
  modport master (output data_in, valid_in, ready_out,
                  input  pop, data_out, valid_out);
`endif

endinterface

// File: rtl/mux_rr_arb_rr_pick.sv
// Rotating priority encoder: grants the first set req bit after base,
// wrapping N-1 -> 0, with base itself searched last.
module rr_pick #(
  parameter int N  = 4,
  parameter int CW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] base,
  output logic [CW-1:0] gnt_idx,
  output logic          gnt_any
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    // Walk from the farthest offset down so the nearest requester wins.
    for (int i = N; i >= 1; i--) begin
      if (req[(int'(base) + i) % N]) begin
        gnt_any = 1'b1;
        gnt_idx = CW'((int'(base) + i) % N);
      end
    end
  end

endmodule

// File: rtl/mux_rr_arb.sv
// N:1 round-robin word mux with bounded bursts and a registered ready/valid
// output. Define MUX_RR_CHAN_ID_EN to add the chan_out source tag.
module mux_rr_arb
  import mux_rr_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int WIDTH = DEF_WIDTH,
  parameter int BURST = DEF_BURST
) (
  input  logic         clk,
  input  logic         reset,
  mux_rr_arb_if.slave  bus
);

  localparam int CW = clog2(N);

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_last, w_last_nxt;
  logic [BCW-1:0]   r_burst_cnt, w_burst_nxt;
  logic [WIDTH-1:0] r_data, w_data_nxt;
  logic             r_valid, w_valid_nxt;
  logic             w_free, w_cont, w_load, w_pick_any;
  logic [CW-1:0]    w_pick_idx, w_g;
  logic [N-1:0]     w_pop;
`ifdef MUX_RR_CHAN_ID_EN
  logic [CW-1:0]    r_chan, w_chan_nxt;
`endif

  rr_pick #(.N(N), .CW(CW)) u_pick (
    .req     (bus.valid_in),
    .base    (r_last),
    .gnt_idx (w_pick_idx),
    .gnt_any (w_pick_any)
  );

  always_comb begin
    w_free      = !r_valid || bus.ready_out;
    w_cont      = (r_state == ST_OWN) && bus.valid_in[r_last]
                  && (r_burst_cnt < BCW'(BURST));
    w_g         = w_cont ? r_last : w_pick_idx;
    w_load      = w_free && (w_cont || w_pick_any) && !reset;
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_burst_nxt = r_burst_cnt;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_pop       = '0;
`ifdef MUX_RR_CHAN_ID_EN
    w_chan_nxt  = r_chan;
`endif
    if (w_free) begin
      if (w_cont || w_pick_any) begin
        w_pop[w_g]  = w_load;
        w_data_nxt  = bus.data_in[int'(w_g)*WIDTH +: WIDTH];
        w_valid_nxt = 1'b1;
        w_last_nxt  = w_g;
`ifdef MUX_RR_CHAN_ID_EN
        w_chan_nxt  = w_g;
`endif
        if (w_cont) begin
          w_burst_nxt = r_burst_cnt + 1'b1;
        end else begin
          w_burst_nxt = BCW'(1);
          // A single-word burst never owns the lane, so it stays in IDLE.
          w_state_nxt = (BURST > 1) ? ST_OWN : ST_IDLE;
        end
      end else begin
        w_valid_nxt = 1'b0;
        w_burst_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_last      <= CW'(N - 1);
      r_burst_cnt <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
`ifdef MUX_RR_CHAN_ID_EN
      r_chan      <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_last      <= w_last_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_data      <= w_data_nxt;
      r_valid     <= w_valid_nxt;
`ifdef MUX_RR_CHAN_ID_EN
      r_chan      <= w_chan_nxt;
`endif
    end
  end

  assign bus.pop       = w_pop;
  assign bus.data_out  = r_data;
  assign bus.valid_out = r_valid;
`ifdef MUX_RR_CHAN_ID_EN
  assign bus.chan_out  = r_chan;
`endif

endmodule

// File: tb/tb_mux_rr_arb.sv
// Randomized and directed bench for mux_rr_arb against a grant-rule model
// kept as plain integers (previous owner, run length, pending words).
module tb_mux_rr_arb;

  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int BURST = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mux_rr_arb_if #(.N(N), .WIDTH(WIDTH)) bus();

  mux_rr_arb #(.N(N), .WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: next word each channel's FIFO presents, the previous
  // grant, how many consecutive words it has had, and the expected output.
  logic [WIDTH-1:0] m_word [N];
  int               m_last;
  int               m_run;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_chan;
  logic [N-1:0]     exp_pop;
  logic [N-1:0]     got_pop;

  task automatic model_reset();
    m_last  = N - 1;
    m_run   = 0;
    m_valid = 1'b0;
    m_data  = '0;
    m_chan  = 0;
  endtask

  function automatic bit model_keeps(input logic [N-1:0] v);
    return (m_run > 0) && (m_run < BURST) && v[m_last];
  endfunction

  function automatic int model_pick(input logic [N-1:0] v);
    if (model_keeps(v)) return m_last;
    for (int d = 1; d <= N; d++) begin
      if (v[(m_last + d) % N]) return (m_last + d) % N;
    end
    return -1;
  endfunction

  // Drives one cycle (entered 1 time unit after a rising edge), records the
  // combinational pop, and advances the model across the edge.
  task automatic drive_cycle(input logic [N-1:0] v, input logic rdy);
    int  g;
    bit  keep;
    bus.valid_in  = v;
    bus.ready_out = rdy;
    for (int i = 0; i < N; i++) bus.data_in[i*WIDTH +: WIDTH] = m_word[i];
    #1;
    got_pop = bus.pop;
    exp_pop = '0;
    g       = -1;
    keep    = model_keeps(v);
    if (!m_valid || rdy) begin
      g = model_pick(v);
      if (g >= 0) exp_pop[g] = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!m_valid || rdy) begin
      if (g >= 0) begin
        m_run     = keep ? m_run + 1 : 1;
        m_last    = g;
        m_data    = m_word[g];
        m_chan    = g;
        m_valid   = 1'b1;
        m_word[g] = m_word[g] + 1'b1;
      end else begin
        m_valid = 1'b0;
        m_run   = 0;
      end
    end
  endtask

  task automatic do_reset();
    bus.valid_in = '0;
    #2 reset = 1'b1;
    model_reset();
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.valid_in  = '1;
    bus.ready_out = 1'b1;
    bus.data_in   = '1;
    model_reset();
    #12;
    n_checks++;
    if (bus.pop !== '0) begin
      n_errors++; $display("FAIL reset_pop got %b exp 0", bus.pop);
    end
    n_checks++;
    if (bus.valid_out !== 1'b0) begin
      n_errors++; $display("FAIL reset_valid got %b exp 0", bus.valid_out);
    end
    n_checks++;
    if (bus.data_out !== '0) begin
      n_errors++; $display("FAIL reset_data got %h exp 0", bus.data_out);
    end
`ifdef MUX_RR_CHAN_ID_EN
    n_checks++;
    if (bus.chan_out !== '0) begin
      n_errors++; $display("FAIL reset_chan got %0d exp 0", bus.chan_out);
    end
`endif
    bus.valid_in = '0;
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_first_word();
    m_word[0] = 8'hA5;
    drive_cycle(4'b0001, 1'b1);
    n_checks++;
    if (got_pop !== 4'b0001) begin
      n_errors++; $display("FAIL first_pop got %b exp 0001", got_pop);
    end
    n_checks++;
    if (bus.data_out !== 8'hA5 || bus.valid_out !== 1'b1) begin
      n_errors++;
      $display("FAIL first_out got %h/%b exp a5/1", bus.data_out, bus.valid_out);
    end
  endtask

  task automatic test_all_valid();
    int exp_seq [12] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 1};
    int gi;
    do_reset();
    for (int i = 0; i < N; i++) m_word[i] = WIDTH'(8'h10 * i);
    for (int c = 0; c < 12; c++) begin
      drive_cycle('1, 1'b1);
      gi = -1;
      for (int i = 0; i < N; i++) if (got_pop[i]) gi = i;
      n_checks++;
      if ($countones(got_pop) != 1 || gi != exp_seq[c]) begin
        n_errors++;
        $display("FAIL rr_grant cyc %0d got %b exp ch%0d", c, got_pop, exp_seq[c]);
      end
      n_checks++;
      if (bus.data_out !== m_data || bus.valid_out !== 1'b1) begin
        n_errors++;
        $display("FAIL rr_data cyc %0d got %h exp %h", c, bus.data_out, m_data);
      end
    end
  endtask

  task automatic test_single_channel();
    for (int c = 0; c < 6; c++) begin
      drive_cycle(4'b0100, 1'b1);
      n_checks++;
      if (got_pop !== 4'b0100) begin
        n_errors++; $display("FAIL single_pop cyc %0d got %b exp 0100", c, got_pop);
      end
      n_checks++;
      if (bus.valid_out !== 1'b1 || bus.data_out !== m_data) begin
        n_errors++;
        $display("FAIL single_out cyc %0d got %h/%b exp %h/1", c, bus.data_out,
                 bus.valid_out, m_data);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] held;
    drive_cycle('1, 1'b1);
    drive_cycle('1, 1'b1);
    held = bus.data_out;
    for (int c = 0; c < 3; c++) begin
      drive_cycle('1, 1'b0);
      n_checks++;
      if (got_pop !== '0) begin
        n_errors++; $display("FAIL bp_pop cyc %0d got %b exp 0", c, got_pop);
      end
      n_checks++;
      if (bus.data_out !== held || bus.valid_out !== 1'b1) begin
        n_errors++;
        $display("FAIL bp_hold cyc %0d got %h/%b exp %h/1", c, bus.data_out,
                 bus.valid_out, held);
      end
    end
    for (int c = 0; c < 3; c++) begin
      drive_cycle('1, 1'b1);
      n_checks++;
      if (got_pop !== exp_pop || $countones(got_pop) != 1) begin
        n_errors++; $display("FAIL bp_resume cyc %0d got %b exp %b", c, got_pop, exp_pop);
      end
      n_checks++;
      if (bus.data_out !== m_data) begin
        n_errors++; $display("FAIL bp_data cyc %0d got %h exp %h", c, bus.data_out, m_data);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    drive_cycle('1, 1'b1);
    drive_cycle('1, 1'b1);
    drive_cycle('1, 1'b1);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (bus.valid_out !== 1'b0 || bus.pop !== '0) begin
      n_errors++;
      $display("FAIL async_reset got valid %b pop %b exp 0/0", bus.valid_out, bus.pop);
    end
    model_reset();
    @(negedge clk) reset = 1'b0;
    drive_cycle('1, 1'b1);
    n_checks++;
    if (got_pop !== 4'b0001) begin
      n_errors++; $display("FAIL post_reset_pop got %b exp 0001", got_pop);
    end
    n_checks++;
    if (bus.data_out !== m_data || bus.valid_out !== 1'b1) begin
      n_errors++; $display("FAIL post_reset_data got %h exp %h", bus.data_out, m_data);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] v;
    logic         r;
    for (int c = 0; c < 400; c++) begin
      v = N'($urandom_range(0, (1 << N) - 1));
      r = ($urandom_range(0, 3) != 0);
      drive_cycle(v, r);
      n_checks++;
      if (got_pop !== exp_pop) begin
        n_errors++; $display("FAIL rand_pop cyc %0d got %b exp %b", c, got_pop, exp_pop);
      end
      n_checks++;
      if (bus.valid_out !== m_valid) begin
        n_errors++; $display("FAIL rand_valid cyc %0d got %b exp %b", c, bus.valid_out, m_valid);
      end
      if (m_valid) begin
        n_checks++;
        if (bus.data_out !== m_data) begin
          n_errors++; $display("FAIL rand_data cyc %0d got %h exp %h", c, bus.data_out, m_data);
        end
`ifdef MUX_RR_CHAN_ID_EN
        n_checks++;
        if (int'(bus.chan_out) != m_chan) begin
          n_errors++; $display("FAIL rand_chan cyc %0d got %0d exp %0d", c, bus.chan_out, m_chan);
        end
`endif
      end
    end
  endtask

`ifdef MUX_RR_CHAN_ID_EN
  task automatic test_chan_id();
    do_reset();
    drive_cycle(4'b1000, 1'b1);
    n_checks++;
    if (bus.chan_out !== 2'd3 || bus.data_out !== m_data) begin
      n_errors++; $display("FAIL chan_first got %0d/%h exp 3/%h", bus.chan_out, bus.data_out, m_data);
    end
    drive_cycle(4'b0001, 1'b1);
    n_checks++;
    if (bus.chan_out !== 2'd0 || bus.data_out !== m_data) begin
      n_errors++; $display("FAIL chan_second got %0d/%h exp 0/%h", bus.chan_out, bus.data_out, m_data);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < N; i++) m_word[i] = '0;
    test_reset();
    test_first_word();
    test_all_valid();
    test_single_channel();
    test_backpressure();
    test_reset_mid_burst();
    test_random();
`ifdef MUX_RR_CHAN_ID_EN
    test_chan_id();
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
